// File: rtl/branch_unit.sv
// Branch resolver: architectural condition-code register, condition evaluation,
// target adder and a two-state redirect/flush FSM feeding back to fetch.
module branch_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cc_we,
   input  logic [3:0]       cc_in,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_cond,
   input  logic [WIDTH-1:0] br_pc,
   input  logic [WIDTH-1:0] br_offset,
   output logic [3:0]       cc_q,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc,
   output logic             flush,
   output logic             resolved_valid,
   output logic             resolved_taken
);

   typedef enum logic {
      IDLE,
      FLUSH
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cc_d;
   logic             br_ready_q, br_ready_d;
   logic             redirect_valid_q, redirect_valid_d;
   logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic             flush_q, flush_d;
   logic             resolved_valid_q, resolved_valid_d;
   logic             resolved_taken_q, resolved_taken_d;

   logic             accept;
   logic             taken;
   logic [3:0]       cc_eff;
   logic             f_n, f_z, f_c, f_v;
   logic [WIDTH-1:0] target;

   // A same-cycle ALU write is older than the branch, so forward it.
   assign cc_eff = cc_we ? cc_in : cc_q;
   assign f_n    = cc_eff[3];
   assign f_z    = cc_eff[2];
   assign f_c    = cc_eff[1];
   assign f_v    = cc_eff[0];
   assign target = br_pc + br_offset;
   assign accept = br_valid && br_ready_q;

   always_comb begin
      taken = 1'b0;
      unique case (br_cond)
         4'd0:    taken = 1'b1;
         4'd1:    taken = f_z;
         4'd2:    taken = !f_z;
         4'd3:    taken = f_c;
         4'd4:    taken = !f_c;
         4'd5:    taken = f_n;
         4'd6:    taken = !f_n;
         4'd7:    taken = f_v;
         4'd8:    taken = !f_v;
         4'd9:    taken = f_c && !f_z;
         4'd10:   taken = !f_c || f_z;
         4'd11:   taken = (f_n == f_v);
         4'd12:   taken = (f_n != f_v);
         4'd13:   taken = !f_z && (f_n == f_v);
         4'd14:   taken = f_z || (f_n != f_v);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      redirect_valid_d = 1'b0;
      flush_d          = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      resolved_valid_d = 1'b0;
      resolved_taken_d = resolved_taken_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               resolved_valid_d = 1'b1;
               resolved_taken_d = taken;
               if (taken) begin
                  state_d          = FLUSH;
                  redirect_valid_d = 1'b1;
                  flush_d          = 1'b1;
                  redirect_pc_d    = target;
               end
            end
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      br_ready_d = (state_d == IDLE);
   end

   // cc_we during the flush cycle belongs to the squashed wrong-path op.
   always_comb begin
      cc_d = cc_q;
      if (cc_we && !flush_q) cc_d = cc_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         cc_q             <= 4'b0000;
         br_ready_q       <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         resolved_valid_q <= 1'b0;
         resolved_taken_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         cc_q             <= cc_d;
         br_ready_q       <= br_ready_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         resolved_valid_q <= resolved_valid_d;
         resolved_taken_q <= resolved_taken_d;
      end
   end

   assign br_ready       = br_ready_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush          = flush_q;
   assign resolved_valid = resolved_valid_q;
   assign resolved_taken = resolved_taken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: condition table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cc_we;
   logic [3:0]  cc_in;
   logic        br_valid;
   logic        br_ready;
   logic [3:0]  br_cond;
   logic [15:0] br_pc;
   logic [15:0] br_offset;
   logic [3:0]  cc_q;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        flush;
   logic        resolved_valid;
   logic        resolved_taken;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   branch_unit #(.WIDTH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cc_we          (cc_we),
      .cc_in          (cc_in),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_cond        (br_cond),
      .br_pc          (br_pc),
      .br_offset      (br_offset),
      .cc_q           (cc_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .resolved_valid (resolved_valid),
      .resolved_taken (resolved_taken)
   );

   // behavioural model state
   logic [3:0]  m_cc;
   logic        m_ready, m_redir, m_flush, m_resv, m_rest;
   logic [15:0] m_pc;
   bit          in_flush_cycle;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, lt;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      lt = (n != v);
      case (c)
         0:  return 1;
         1:  return z;
         2:  return !z;
         3:  return cy;
         4:  return !cy;
         5:  return n;
         6:  return !n;
         7:  return v;
         8:  return !v;
         9:  return cy && !z;
         10: return !(cy && !z);
         11: return !lt;
         12: return lt;
         13: return !(z || lt);
         14: return z || lt;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_cc = 0; m_ready = 0; m_redir = 0; m_flush = 0;
      m_resv = 0; m_rest = 0; m_pc = 0; in_flush_cycle = 0;
   endtask

   task automatic compare_all(input string name);
      check(name, {7'd0, cc_q, br_ready, redirect_valid, redirect_pc,
                   flush, resolved_valid, resolved_taken},
                  {7'd0, m_cc, m_ready, m_redir, m_pc,
                   m_flush, m_resv, m_rest});
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic cyc(input logic we, input logic [3:0] ci, input logic bv,
                      input logic [3:0] bc, input logic [15:0] pc,
                      input logic [15:0] off, input string name);
      bit acc, tk;
      cc_we = we; cc_in = ci; br_valid = bv; br_cond = bc;
      br_pc = pc; br_offset = off;
      acc = bv && m_ready && !in_flush_cycle;
      tk  = cond_ok(bc, we ? ci : m_cc);
      @(posedge clk);
      #1;
      if (we && !in_flush_cycle) m_cc = ci;
      m_redir = acc && tk;
      m_flush = acc && tk;
      if (acc && tk) m_pc = pc + off;
      m_resv = acc;
      if (acc) m_rest = tk;
      m_ready = !(acc && tk);
      in_flush_cycle = acc && tk;
      compare_all(name);
   endtask

   task automatic idle(input string name);
      cyc(0, 0, 0, 0, 0, 0, name);
   endtask

   typedef struct {
      logic [3:0] cc;
      logic [3:0] cond;
      logic       tk;
   } vec_t;

   vec_t tbl[18];
   int   pulses;

   initial begin
      tbl[0]  = '{4'b1000, 4'd12, 1'b1};
      tbl[1]  = '{4'b1000, 4'd11, 1'b0};
      tbl[2]  = '{4'b0000, 4'd13, 1'b1};
      tbl[3]  = '{4'b0100, 4'd14, 1'b1};
      tbl[4]  = '{4'b0100, 4'd1,  1'b1};
      tbl[5]  = '{4'b0000, 4'd2,  1'b1};
      tbl[6]  = '{4'b0010, 4'd3,  1'b1};
      tbl[7]  = '{4'b0000, 4'd4,  1'b1};
      tbl[8]  = '{4'b1000, 4'd5,  1'b1};
      tbl[9]  = '{4'b1000, 4'd6,  1'b0};
      tbl[10] = '{4'b0001, 4'd7,  1'b1};
      tbl[11] = '{4'b0001, 4'd8,  1'b0};
      tbl[12] = '{4'b0010, 4'd9,  1'b1};
      tbl[13] = '{4'b0110, 4'd10, 1'b1};
      tbl[14] = '{4'b1001, 4'd11, 1'b1};
      tbl[15] = '{4'b1111, 4'd15, 1'b0};
      tbl[16] = '{4'b0000, 4'd0,  1'b1};
      tbl[17] = '{4'b0101, 4'd13, 1'b0};

      rst_n = 0; cc_we = 0; cc_in = 0; br_valid = 0;
      br_cond = 0; br_pc = 0; br_offset = 0;
      model_reset();
      #23;
      check("rst_cc", cc_q, 0);
      check("rst_ready", br_ready, 0);
      check("rst_redir", redirect_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_pc", redirect_pc, 0);
      check("rst_resv", resolved_valid, 0);

      // reset release, then flags
      rst_n = 1;
      cyc(1, 4'b0100, 0, 0, 0, 0, "flags_load");
      check("ready_after_rel", br_ready, 1);
      check("cc_loaded", cc_q, 4'b0100);

      // forwarding: cc_q=0 but same-cycle write sets Z
      cyc(1, 4'b0000, 0, 0, 0, 0, "clear_cc");
      cyc(1, 4'b0100, 1, 4'd1, 16'h0010, 16'h0020, "fwd");
      check("fwd_redir", redirect_valid, 1);
      check("fwd_flush", flush, 1);
      check("fwd_pc", redirect_pc, 16'h0030);
      check("fwd_taken", resolved_taken, 1);
      check("fwd_ready", br_ready, 0);
      idle("fwd_ret");
      check("fwd_ready_back", br_ready, 1);
      check("fwd_redir_drop", redirect_valid, 0);

      // back-to-back not-taken
      cyc(1, 4'b0000, 0, 0, 0, 0, "nt_load");
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 4'd1, 16'h0100, 16'h0004, "nt_b2b");
         if (resolved_valid && !resolved_taken && !redirect_valid && br_ready)
            pulses++;
      end
      check("nt_pulses", pulses, 3);
      check("nt_pc_held", redirect_pc, 16'h0030);
      idle("nt_end");

      // wrap-around and flush-cycle CC suppression
      cyc(1, 4'b0010, 0, 0, 0, 0, "wrap_load");
      cyc(0, 0, 1, 4'd0, 16'hFFF0, 16'h0020, "wrap");
      check("wrap_pc", redirect_pc, 16'h0010);
      cyc(1, 4'b1111, 1, 4'd0, 16'h1234, 16'h0000, "flush_we");
      check("flush_cc_kept", cc_q, 4'b0010);
      check("flush_no_accept", resolved_valid, 0);
      idle("wrap_end");

      // condition table
      foreach (tbl[i]) begin
         cyc(1, tbl[i].cc, 0, 0, 0, 0, "tbl_load");
         cyc(0, 0, 1, tbl[i].cond, 16'($urandom), 16'($urandom), "tbl_br");
         check($sformatf("tbl%0d_taken", i), {resolved_valid, resolved_taken},
               {1'b1, tbl[i].tk});
         idle("tbl_gap");
      end

      // reset during the redirect cycle
      cyc(1, 4'b1010, 0, 0, 0, 0, "rf_load");
      cyc(0, 0, 1, 4'd0, 16'h0200, 16'h0040, "rf_br");
      check("rf_in_flush", flush, 1);
      #1 rst_n = 0;
      #1;
      check("rf_redir0", redirect_valid, 0);
      check("rf_flush0", flush, 0);
      check("rf_cc0", cc_q, 0);
      check("rf_resv0", resolved_valid, 0);
      rst_n = 1;
      model_reset();
      #1;
      check("rf_ready_before_edge", br_ready, 0);
      idle("rf_edge");
      check("rf_ready_after_edge", br_ready, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 9) < 7),
             4'($urandom), 16'($urandom), 16'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
